rom_arbiter: RTL and testbench
==============================

Name: rom_arbiter

Overview:
- Shares one synchronous-read ROM (1-cycle read latency, reads gated by a chip-enable) between two requesters. Typical pairing: the CPU instruction/data fetch on port 0, and a secondary client (loader verify, debug/OSD peek) on port 1.
- Each port uses a level request and a single-cycle acknowledge; read data is registered per port.
- Arbitration is round-robin, or fixed priority to port 0, selected by parameter.
- Sits between the requesters and the ROM instance; drives the ROM's clock-enable and address.

Parameters:
- AW, 14, ROM address width in bits (14 = 16 KB).
- RR, 1, arbitration mode: 1 = round-robin on tie, 0 = port 0 always wins a tie.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  port 0 read request; level signal, held until ack0.
- a0  in  AW  port 0 address; stable while req0 is high.
- ack0  out  1  one-cycle pulse; q0 is valid from this cycle onward.
- q0  out  8  port 0 read data; holds until the next ack0.
- req1, a1, ack1, q1: same as port 0, for port 1.
- rom_ce  out  1  ROM clock-enable.
- rom_a  out  AW  ROM address.
- rom_q  in  8  ROM registered output; valid the cycle after the ROM samples rom_ce=1.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state=IDLE; ack0=ack1=0; q0=q1=0; rom_ce=0; rom_a=0; busy=0; last_grant=1 (so port 0 wins the first tie). Reset mid-access aborts the access: no ack is issued and q is cleared.
- All outputs are registered.
- FSM states: IDLE, ISSUE, DATA, ACK.
- IDLE:
  - req is sampled only in this state.
  - No request: stay in IDLE, rom_ce=0.
  - One request: grant that port.
  - Both requests: if RR=1, grant the port != last_grant; if RR=0, grant port 0.
  - On grant: register rom_a <= a_sel, rom_ce <= 1, gnt <= port, last_grant <= port; go to ISSUE.
- ISSUE: rom_ce=1 for exactly this cycle; the ROM samples at the end of the cycle. Next state DATA; rom_ce <= 0.
- DATA: rom_q is valid. Capture q_gnt <= rom_q and ack_gnt <= 1; go to ACK.
- ACK:
  - ack_gnt is high for this single cycle; the other port's ack stays 0 and its q is untouched.
  - req inputs are ignored in this state.
  - Next state IDLE; ack <= 0.
- Timing:
  - Latency: req high before edge E, with the arbiter in IDLE → ack visible in the cycle after edge E+2, i.e. 3 cycles.
  - Throughput: one access per 4 cycles per arbiter.
- Requester protocol:
  - Deassert req in the cycle ack is seen.
  - A req still high when the arbiter returns to IDLE is a new request and is re-read.
- rom_a holds its last value outside ISSUE. The arbiter uses its registered copy of the address, so a change on a0/a1 after grant has no effect.
- Starvation: with RR=1 and both ports continuously requesting, grants alternate 0,1,0,1. With RR=0, port 1 is served only when req0 is low in IDLE.
- A request that drops before it is granted is never served; there is no ack and no ROM access.
- ack0 and ack1 are never high in the same cycle.
- rom_ce is never high for more than one consecutive cycle.

Test Plan:
- Reset then single read: ROM preloaded with rom[0x0000]=0xF3. Pulse req0 with a0=0x0000 → rom_ce high exactly 1 cycle with rom_a=0x0000; ack0 high 3 cycles after the req0 sample edge; q0=0xF3; ack1=0; q1=0.
- Simultaneous requests, RR=1: rom[0x0001]=0xAF, rom[0x3FFF]=0x5A. req0 (a0=0x0001) and req1 (a1=0x3FFF) raised in the same cycle → port 0 served first (q0=0xAF), then port 1 (q1=0x5A). Both held for 8 accesses → grant order 0,1,0,1,…
- Fixed priority, RR=0: req0 and req1 continuously high → only ack0 pulses. Drop req0 → the next IDLE grants port 1.
- Address change after grant: a0 changes from 0x0001 to 0x0002 during ISSUE → q0=0xAF (original address).
- Reset mid-access: assert reset during DATA → no ack in any following cycle; q0=0; busy=0; rom_ce=0.
- Held req: keep req1 high through ack1 → a second access to the same address starts in the next IDLE; busy stays high except for 1 IDLE cycle.

Source files
------------

// File: rtl/rom_arbiter_if.sv
// rtl/rom_arbiter_if.sv - requester-side bus for the two-port ROM arbiter
// Port 0 and port 1 each carry a level request, address, one-cycle ack and read data.
interface rom_arbiter_if #(parameter int AW = 14);
   logic          req0;
   logic [AW-1:0] a0;
   logic          ack0;
   logic [7:0]    q0;
   logic          req1;
   logic [AW-1:0] a1;
   logic          ack1;
   logic [7:0]    q1;

   modport master (output req0, a0, req1, a1, input ack0, q0, ack1, q1);
   modport slave  (input req0, a0, req1, a1, output ack0, q0, ack1, q1);
endinterface

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - two-port arbiter in front of a 1-cycle synchronous-read ROM
// One access per four cycles: IDLE grants, ISSUE strobes the ROM, DATA captures, ACK pulses.
module rom_arbiter #(
   parameter int AW = 14,
   parameter int RR = 1
) (
   input  logic          clock,
   input  logic          reset,
   rom_arbiter_if.slave  bus,
   output logic          rom_ce,
   output logic [AW-1:0] rom_a,
   input  logic [7:0]    rom_q,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, DATA, ACK} state_t;

   state_t        state, state_d;
   logic          gnt, gnt_d;
   logic          last_grant, last_grant_d;
   logic          rom_ce_d;
   logic [AW-1:0] rom_a_d;
   logic          ack0_r, ack0_d, ack1_r, ack1_d;
   logic [7:0]    q0_r, q0_d, q1_r, q1_d;
   logic          busy_d;
   logic          pick;

   assign bus.ack0 = ack0_r;
   assign bus.ack1 = ack1_r;
   assign bus.q0   = q0_r;
   assign bus.q1   = q1_r;

   always_comb begin
      state_d      = state;
      gnt_d        = gnt;
      last_grant_d = last_grant;
      rom_ce_d     = 1'b0;
      rom_a_d      = rom_a;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      q0_d         = q0_r;
      q1_d         = q1_r;
      pick         = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               // On a tie, round-robin favours whichever port was not served last
               if (bus.req0 && bus.req1)
                  pick = (RR != 0) ? ~last_grant : 1'b0;
               else
                  pick = bus.req1;
               gnt_d        = pick;
               last_grant_d = pick;
               rom_a_d      = pick ? bus.a1 : bus.a0;
               rom_ce_d     = 1'b1;
               state_d      = ISSUE;
            end
         end
         ISSUE: state_d = DATA;
         DATA: begin
            if (gnt) begin
               q1_d   = rom_q;
               ack1_d = 1'b1;
            end else begin
               q0_d   = rom_q;
               ack0_d = 1'b1;
            end
            state_d = ACK;
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         gnt        <= 1'b0;
         last_grant <= 1'b1;
         rom_ce     <= 1'b0;
         rom_a      <= '0;
         ack0_r     <= 1'b0;
         ack1_r     <= 1'b0;
         q0_r       <= 8'h00;
         q1_r       <= 8'h00;
         busy       <= 1'b0;
      end else begin
         state      <= state_d;
         gnt        <= gnt_d;
         last_grant <= last_grant_d;
         rom_ce     <= rom_ce_d;
         rom_a      <= rom_a_d;
         ack0_r     <= ack0_d;
         ack1_r     <= ack1_d;
         q0_r       <= q0_d;
         q1_r       <= q1_d;
         busy       <= busy_d;
      end
   end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - directed checks of rom_arbiter in round-robin and fixed-priority modes
// Outputs are sampled and inputs driven on the falling edge; the ROM is a behavioural array.
module tb_rom_arbiter;

   localparam int AW = 14;

   logic          clock;
   logic          reset;
   logic          ce_a, ce_b, busy_a, busy_b;
   logic [AW-1:0] ra_a, ra_b;
   logic [7:0]    rq_a, rq_b;
   logic [7:0]    mem [0:(1<<AW)-1];
   int            n_checks;
   int            n_fail;

   rom_arbiter_if #(.AW(AW)) ifa ();
   rom_arbiter_if #(.AW(AW)) ifb ();

   rom_arbiter #(.AW(AW), .RR(1)) dut_a (
      .clock (clock), .reset (reset), .bus (ifa),
      .rom_ce (ce_a), .rom_a (ra_a), .rom_q (rq_a), .busy (busy_a)
   );

   rom_arbiter #(.AW(AW), .RR(0)) dut_b (
      .clock (clock), .reset (reset), .bus (ifb),
      .rom_ce (ce_b), .rom_a (ra_b), .rom_q (rq_b), .busy (busy_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) if (ce_a) rq_a <= mem[ra_a];
   always @(posedge clock) if (ce_b) rq_b <= mem[ra_b];

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge clock);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rq_a = 8'h00;
      rq_b = 8'h00;
      for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i ^ (i >> 8));
      mem[14'h0000] = 8'hF3;
      mem[14'h0001] = 8'hAF;
      mem[14'h0002] = 8'h11;
      mem[14'h3FFF] = 8'h5A;
      ifa.req0 = 0; ifa.a0 = '0; ifa.req1 = 0; ifa.a1 = '0;
      ifb.req0 = 0; ifb.a0 = '0; ifb.req1 = 0; ifb.a1 = '0;
      reset = 1'b1;
      tick(2);
      check("rst_ack0", 32'(ifa.ack0), 0);
      check("rst_ack1", 32'(ifa.ack1), 0);
      check("rst_q0",   32'(ifa.q0),   0);
      check("rst_q1",   32'(ifa.q1),   0);
      check("rst_ce",   32'(ce_a),     0);
      check("rst_a",    32'(ra_a),     0);
      check("rst_busy", 32'(busy_a),   0);
      check("rst_busy_b", 32'(busy_b), 0);
      reset = 1'b0;

      // single read of address 0
      ifa.req0 = 1; ifa.a0 = 14'h0000;
      tick(1);
      check("s_issue_ce",   32'(ce_a),     1);
      check("s_issue_a",    32'(ra_a),     0);
      check("s_issue_busy", 32'(busy_a),   1);
      check("s_issue_ack0", 32'(ifa.ack0), 0);
      tick(1);
      check("s_data_ce",    32'(ce_a),     0);
      check("s_data_ack0",  32'(ifa.ack0), 0);
      tick(1);
      check("s_ack0",       32'(ifa.ack0), 1);
      check("s_q0",         32'(ifa.q0),   32'hF3);
      check("s_ack1",       32'(ifa.ack1), 0);
      check("s_q1",         32'(ifa.q1),   0);
      ifa.req0 = 0;
      tick(1);
      check("s_idle_ack0",  32'(ifa.ack0), 0);
      check("s_idle_busy",  32'(busy_a),   0);
      check("s_idle_q0",    32'(ifa.q0),   32'hF3);

      // address change after grant is ignored
      ifa.req0 = 1; ifa.a0 = 14'h0001;
      tick(1);
      check("ac_rom_a", 32'(ra_a), 1);
      ifa.a0 = 14'h0002;
      tick(2);
      check("ac_ack0", 32'(ifa.ack0), 1);
      check("ac_q0",   32'(ifa.q0),   32'hAF);
      ifa.req0 = 0;
      tick(1);

      // round-robin with both ports held for 8 accesses
      reset = 1'b1; tick(1); reset = 1'b0;
      ifa.req0 = 1; ifa.a0 = 14'h0001;
      ifa.req1 = 1; ifa.a1 = 14'h3FFF;
      for (int k = 0; k < 8; k++) begin
         tick(1);
         check("rr_rom_a", 32'(ra_a), (k % 2 == 0) ? 32'h0001 : 32'h3FFF);
         check("rr_ce",    32'(ce_a), 1);
         tick(2);
         check("rr_ack0", 32'(ifa.ack0), (k % 2 == 0) ? 1 : 0);
         check("rr_ack1", 32'(ifa.ack1), (k % 2 == 1) ? 1 : 0);
         if (k % 2 == 0) check("rr_q0", 32'(ifa.q0), 32'hAF);
         else            check("rr_q1", 32'(ifa.q1), 32'h5A);
         if (k == 7) begin
            ifa.req0 = 0;
            ifa.req1 = 0;
         end
         tick(1);
         check("rr_idle_busy", 32'(busy_a), 0);
      end

      // fixed priority: port 1 waits until req0 drops
      ifb.req0 = 1; ifb.a0 = 14'h0001;
      ifb.req1 = 1; ifb.a1 = 14'h3FFF;
      for (int k = 0; k < 3; k++) begin
         tick(3);
         check("fp_ack0", 32'(ifb.ack0), 1);
         check("fp_ack1", 32'(ifb.ack1), 0);
         if (k == 2) ifb.req0 = 0;
         tick(1);
      end
      tick(1);
      check("fp_rom_a", 32'(ra_b), 32'h3FFF);
      tick(2);
      check("fp_ack1_late", 32'(ifb.ack1), 1);
      check("fp_ack0_late", 32'(ifb.ack0), 0);
      check("fp_q1",        32'(ifb.q1),   32'h5A);
      ifb.req1 = 0;
      tick(1);
      check("fp_idle_busy", 32'(busy_b), 0);

      // reset during DATA aborts the access
      ifa.req0 = 1; ifa.a0 = 14'h0000;
      tick(2);
      check("ra_data_busy", 32'(busy_a), 1);
      check("ra_data_ce",   32'(ce_a),   0);
      reset = 1'b1; ifa.req0 = 0;
      tick(1);
      check("ra_ack0", 32'(ifa.ack0), 0);
      check("ra_q0",   32'(ifa.q0),   0);
      check("ra_q1",   32'(ifa.q1),   0);
      check("ra_busy", 32'(busy_a),   0);
      check("ra_ce",   32'(ce_a),     0);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick(1);
         check("ra_no_ack", 32'({ifa.ack0, ifa.ack1}), 0);
      end

      // req1 held through ack starts a second access after one IDLE cycle
      ifa.req1 = 1; ifa.a1 = 14'h3FFF;
      tick(1);
      check("h_ce1",   32'(ce_a), 1);
      check("h_a1",    32'(ra_a), 32'h3FFF);
      tick(2);
      check("h_ack1",  32'(ifa.ack1), 1);
      check("h_q1",    32'(ifa.q1),   32'h5A);
      check("h_busy_ack", 32'(busy_a), 1);
      tick(1);
      check("h_idle_busy", 32'(busy_a),   0);
      check("h_idle_ack1", 32'(ifa.ack1), 0);
      tick(1);
      check("h_ce2",   32'(ce_a),   1);
      check("h_a2",    32'(ra_a),   32'h3FFF);
      check("h_busy2", 32'(busy_a), 1);
      tick(1);
      check("h_ce_off", 32'(ce_a),  0);
      tick(1);
      check("h_ack1_2", 32'(ifa.ack1), 1);
      check("h_ack0_2", 32'(ifa.ack0), 0);
      ifa.req1 = 0;
      tick(1);
      check("h_end_busy", 32'(busy_a), 0);
      tick(1);
      check("h_end_ce",   32'(ce_a),   0);
      check("h_end_busy2", 32'(busy_a), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
